// File: rtl/wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types and helpers for the Wishbone B4 classic round-robin arbiter.
//   - arb_state_e : arbiter state (no grant / one controller granted)
//   - idx_width() : bits needed to hold a controller index
// ----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  // A single controller would still need a one-bit index field, so clamp at 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : wb_arb_pkg

// File: rtl/wb_rr_picker.sv
// ----------------------------------------------------------------------------
// wb_rr_picker
//   Combinational round-robin search. Starting just after ptr_i and wrapping
//   modulo NUM_CTL, returns the first index whose request bit is set. The
//   index equal to ptr_i is examined last, which is what gives the most
//   recently served controller the lowest priority.
//
// Ports
//   req_i     in   NUM_CTL  request vector (one bit per controller)
//   ptr_i     in   IW       index served most recently
//   found_o   out  1        at least one request bit is set
//   winner_o  out  IW       chosen index (0 when found_o is low)
// ----------------------------------------------------------------------------
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_CTL = 4
) (
  input  logic [NUM_CTL-1:0]               req_i,
  input  logic [idx_width(NUM_CTL)-1:0]    ptr_i,
  output logic                             found_o,
  output logic [idx_width(NUM_CTL)-1:0]    winner_o
);

  localparam int IW = idx_width(NUM_CTL);

  int          cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk ptr+1 .. ptr+NUM_CTL; the last step lands back on ptr itself.
    for (int i = 1; i <= NUM_CTL; i++) begin
      cand     = (int'(ptr_i) + i) % NUM_CTL;
      cand_idx = cand[IW-1:0];
      if (!found_o && req_i[cand_idx]) begin
        found_o  = 1'b1;
        winner_o = cand_idx;
      end
    end
  end

endmodule : wb_rr_picker

// File: rtl/wb_classic_arbiter.sv
// ----------------------------------------------------------------------------
// wb_classic_arbiter
//   Shares one Wishbone B4 classic device between NUM_CTL controllers using
//   round-robin arbitration. Exactly one controller is granted at a time; its
//   request is routed to the device and the device response is returned to it
//   alone. A grant lasts for as long as the granted controller holds cyc, so
//   back-to-back classic cycles from one controller are never interleaved.
//
// Handshake: a classic transfer is "valid" while cyc & stb are high; the
//   device completes it by asserting exactly one of ack/err/rty ("ready") in
//   the same cycle. The controller keeps stb/we/dat stable until then. The
//   arbiter adds no cycles to this path: request and response are both
//   routed combinationally through the current grant.
//
// Ports
//   clk_i           in   1              clock, rising edge
//   rst_ni          in   1              asynchronous active-low reset
//   ctl_cyc_i       in   NUM_CTL        per-controller cyc
//   ctl_stb_i       in   NUM_CTL        per-controller stb
//   ctl_we_i        in   NUM_CTL        per-controller we
//   ctl_dat_i       in   NUM_CTL*DW     per-controller write data, ctl k at [k*DW +: DW]
//   ctl_ack_o       out  NUM_CTL        per-controller ack
//   ctl_err_o       out  NUM_CTL        per-controller err
//   ctl_rty_o       out  NUM_CTL        per-controller rty
//   ctl_dat_o       out  DW             read data, broadcast to every controller
//   dev_cyc_o       out  1              device cyc
//   dev_stb_o       out  1              device stb
//   dev_we_o        out  1              device we
//   dev_dat_o       out  DW             device write data
//   dev_ack_i       in   1              device ack
//   dev_err_i       in   1              device err
//   dev_rty_i       in   1              device rty
//   dev_dat_i       in   DW             device read data
//   gnt_o           out  NUM_CTL        one-hot grant, zero when idle
//   dbg_state_o     out  1              arbiter state (0 idle, 1 granted)
//   dbg_ptr_o       out  IW             round-robin pointer (last index served)
// ----------------------------------------------------------------------------
module wb_classic_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_CTL   = 4,
  parameter int DAT_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  // controller side
  input  logic [NUM_CTL-1:0]             ctl_cyc_i,
  input  logic [NUM_CTL-1:0]             ctl_stb_i,
  input  logic [NUM_CTL-1:0]             ctl_we_i,
  input  logic [NUM_CTL*DAT_WIDTH-1:0]   ctl_dat_i,
  output logic [NUM_CTL-1:0]             ctl_ack_o,
  output logic [NUM_CTL-1:0]             ctl_err_o,
  output logic [NUM_CTL-1:0]             ctl_rty_o,
  output logic [DAT_WIDTH-1:0]           ctl_dat_o,
  // device side
  output logic                           dev_cyc_o,
  output logic                           dev_stb_o,
  output logic                           dev_we_o,
  output logic [DAT_WIDTH-1:0]           dev_dat_o,
  input  logic                           dev_ack_i,
  input  logic                           dev_err_i,
  input  logic                           dev_rty_i,
  input  logic [DAT_WIDTH-1:0]           dev_dat_i,
  // status
  output logic [NUM_CTL-1:0]             gnt_o,
  output logic                           dbg_state_o,
  output logic [idx_width(NUM_CTL)-1:0]  dbg_ptr_o
);

  localparam int IW = idx_width(NUM_CTL);

  // --------------------------------------------------------------------------
  // Registered arbiter state
  // --------------------------------------------------------------------------
  arb_state_e          state_q, state_d;
  logic [IW-1:0]       g_q,     g_d;      // granted index, meaningful when GRANTED
  logic [IW-1:0]       ptr_q,   ptr_d;    // last index served
  logic [NUM_CTL-1:0]  gnt_q,   gnt_d;    // one-hot copy of g_q, zero when IDLE

  logic                pick_found;
  logic [IW-1:0]       pick_winner;
  logic                arbitrate;

  // Unpacked view of the flat write-data bus so it can be indexed by g_q.
  logic [DAT_WIDTH-1:0] ctl_dat_a [NUM_CTL];

  for (genvar k = 0; k < NUM_CTL; k++) begin : g_unpack
    assign ctl_dat_a[k] = ctl_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
  end

  wb_rr_picker #(
    .NUM_CTL (NUM_CTL)
  ) u_picker (
    .req_i    (ctl_cyc_i),
    .ptr_i    (ptr_q),
    .found_o  (pick_found),
    .winner_o (pick_winner)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Arbitration runs whenever nobody holds the bus: either IDLE, or the
  // granted controller has just dropped cyc. In the latter case ptr_q == g_q,
  // so the releasing controller is searched last and a waiting controller is
  // granted on this same edge (GRANTED -> GRANTED, no idle bubble).
  always_comb begin
    arbitrate = (state_q == ARB_IDLE) || !ctl_cyc_i[g_q];
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    if (arbitrate) begin
      if (pick_found) begin
        state_d            = ARB_GRANTED;
        g_d                = pick_winner;
        ptr_d              = pick_winner;
        gnt_d              = '0;
        gnt_d[pick_winner] = 1'b1;
      end else begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    end
  end

  // Reset value of ptr is the highest index so that index 0 is searched first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(NUM_CTL - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Routing
  // --------------------------------------------------------------------------
  // Everything is gated by state_q, so an asynchronous reset silences the
  // device port and all responses at once. Responses are also gated by the
  // granted controller's own cyc: in its release cycle a stray device ack
  // must not reach it, since it no longer has a transfer outstanding.
  always_comb begin
    dev_cyc_o = 1'b0;
    dev_stb_o = 1'b0;
    dev_we_o  = 1'b0;
    dev_dat_o = '0;
    ctl_ack_o = '0;
    ctl_err_o = '0;
    ctl_rty_o = '0;
    if (state_q == ARB_GRANTED) begin
      dev_cyc_o      = ctl_cyc_i[g_q];
      dev_stb_o      = ctl_stb_i[g_q] & ctl_cyc_i[g_q];
      dev_we_o       = ctl_we_i[g_q];
      dev_dat_o      = ctl_dat_a[g_q];
      ctl_ack_o[g_q] = dev_ack_i & ctl_cyc_i[g_q];
      ctl_err_o[g_q] = dev_err_i & ctl_cyc_i[g_q];
      ctl_rty_o[g_q] = dev_rty_i & ctl_cyc_i[g_q];
    end
  end

  // Read data is qualified by each controller's own ack, so no mux is needed.
  assign ctl_dat_o   = dev_dat_i;
  assign gnt_o       = gnt_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

  // --------------------------------------------------------------------------
  // Wishbone classic properties on the device port and the controller ports
  // --------------------------------------------------------------------------
  // Device port: stb only inside cyc; a cycle exists only under a grant.
  a_dev_stb_in_cyc : assert property (@(posedge clk_i) disable iff (!rst_ni)
    dev_stb_o |-> dev_cyc_o);
  a_dev_cyc_granted : assert property (@(posedge clk_i) disable iff (!rst_ni)
    dev_cyc_o |-> (gnt_o != '0));

  // Grant is one-hot or empty and tracks the state.
  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_gnt_matches_state : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ARB_GRANTED) == (gnt_o != '0));

  // Controller ports: responses only to the granted controller, only while
  // it holds cyc, and never to more than one controller.
  a_resp_only_granted : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((ctl_ack_o | ctl_err_o | ctl_rty_o) & ~gnt_o) == '0);
  a_resp_needs_cyc : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((ctl_ack_o | ctl_err_o | ctl_rty_o) & ~ctl_cyc_i) == '0);
  a_resp_single_ctl : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ctl_ack_o | ctl_err_o | ctl_rty_o));

  // Grant is held while the granted controller keeps cyc.
  a_grant_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((state_q == ARB_GRANTED) && ctl_cyc_i[g_q]) |=> $stable(gnt_o));

endmodule : wb_classic_arbiter

// File: tb/tb_wb_classic_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_classic_arbiter
//   Directed, table-driven bench for the 4-controller, 8-bit configuration.
//   Each table row is one clock cycle: inputs are driven just after the rising
//   edge and every output is compared at the falling edge. Hand-written
//   sequences cover round-robin order across handovers and reset mid-cycle.
// ----------------------------------------------------------------------------
module tb_wb_classic_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]   ctl_cyc, ctl_stb, ctl_we;
  logic [N*W-1:0] ctl_dat;
  logic [N-1:0]   ctl_ack, ctl_err, ctl_rty;
  logic [W-1:0]   ctl_rdat;
  logic           dev_cyc, dev_stb, dev_we;
  logic [W-1:0]   dev_wdat;
  logic           dev_ack, dev_err, dev_rty;
  logic [W-1:0]   dev_rdat;
  logic [N-1:0]   gnt;
  logic           dbg_state;
  logic [1:0]     dbg_ptr;

  wb_classic_arbiter #(.NUM_CTL(N), .DAT_WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ctl_cyc_i   (ctl_cyc),
    .ctl_stb_i   (ctl_stb),
    .ctl_we_i    (ctl_we),
    .ctl_dat_i   (ctl_dat),
    .ctl_ack_o   (ctl_ack),
    .ctl_err_o   (ctl_err),
    .ctl_rty_o   (ctl_rty),
    .ctl_dat_o   (ctl_rdat),
    .dev_cyc_o   (dev_cyc),
    .dev_stb_o   (dev_stb),
    .dev_we_o    (dev_we),
    .dev_dat_o   (dev_wdat),
    .dev_ack_i   (dev_ack),
    .dev_err_i   (dev_err),
    .dev_rty_i   (dev_rty),
    .dev_dat_i   (dev_rdat),
    .gnt_o       (gnt),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];   // expected grant order for the round-robin sequence

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string          name;
    logic [N-1:0]   cyc, stb, we;
    logic [N*W-1:0] dat;
    logic           ack, err, rty;
    logic [W-1:0]   rdat;
    logic [N-1:0]   e_gnt;
    logic           e_cyc, e_stb, e_we;
    logic [W-1:0]   e_dat;
    logic [N-1:0]   e_ack, e_err, e_rty;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name,
                         input logic [N-1:0] cyc, input logic [N-1:0] stb, input logic [N-1:0] we,
                         input logic [N*W-1:0] dat,
                         input logic ack, input logic err, input logic rty, input logic [W-1:0] rdat,
                         input logic [N-1:0] e_gnt,
                         input logic e_cyc, input logic e_stb, input logic e_we, input logic [W-1:0] e_dat,
                         input logic [N-1:0] e_ack, input logic [N-1:0] e_err, input logic [N-1:0] e_rty);
    vec_t v;
    v.name = name; v.cyc = cyc; v.stb = stb; v.we = we; v.dat = dat;
    v.ack = ack; v.err = err; v.rty = rty; v.rdat = rdat;
    v.e_gnt = e_gnt; v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_we = e_we; v.e_dat = e_dat;
    v.e_ack = e_ack; v.e_err = e_err; v.e_rty = e_rty;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle_inputs();
    ctl_cyc = '0; ctl_stb = '0; ctl_we = '0; ctl_dat = '0;
    dev_ack = 1'b0; dev_err = 1'b0; dev_rty = 1'b0; dev_rdat = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle_inputs();
    @(negedge clk);
    check("rst_gnt",   32'(gnt),       32'h0);
    check("rst_cyc",   32'(dev_cyc),   32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    check("rst_ptr",   32'(dbg_ptr),   32'h3);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [N*W-1:0] D_ONE = 32'h00A5_0000;   // ctl2 = A5
  localparam logic [N*W-1:0] D_ALL = 32'h3322_1100;   // ctl k = {k,k}

  logic [N*W-1:0] dword;
  logic [N-1:0]   exp_gnt;

  initial begin
    drive_idle_inputs();
    do_reset();

    // name           cyc      stb      we       dat    ack err rty rdat     gnt     cyc stb we dat     ack      err      rty
    // Single request from ctl 2: one cycle of arbitration latency.
    add_vec("idle",      4'b0000, 4'b0000, 4'b0000, '0,    0, 0, 0, 8'h3C,  4'b0000, 0, 0, 0, 8'h00,  4'b0000, 4'b0000, 4'b0000);
    add_vec("req_wait",  4'b0100, 4'b0100, 4'b0100, D_ONE, 0, 0, 0, 8'h00,  4'b0000, 0, 0, 0, 8'h00,  4'b0000, 4'b0000, 4'b0000);
    add_vec("granted",   4'b0100, 4'b0100, 4'b0100, D_ONE, 0, 0, 0, 8'h00,  4'b0100, 1, 1, 1, 8'hA5,  4'b0000, 4'b0000, 4'b0000);
    add_vec("ack2",      4'b0100, 4'b0100, 4'b0100, D_ONE, 1, 0, 0, 8'h5A,  4'b0100, 1, 1, 1, 8'hA5,  4'b0100, 4'b0000, 4'b0000);
    // Release cycle: grant still registered, cyc gone, stray ack not forwarded.
    add_vec("release",   4'b0000, 4'b0000, 4'b0000, '0,    1, 0, 0, 8'h00,  4'b0100, 0, 0, 0, 8'h00,  4'b0000, 4'b0000, 4'b0000);
    add_vec("back_idle", 4'b0000, 4'b0000, 4'b0000, '0,    0, 0, 0, 8'h00,  4'b0000, 0, 0, 0, 8'h00,  4'b0000, 4'b0000, 4'b0000);
    // Hold: ctl 1 keeps cyc through three acks while ctl 3 waits.
    add_vec("c1_req",    4'b0010, 4'b0010, 4'b0000, D_ALL, 0, 0, 0, 8'h00,  4'b0000, 0, 0, 0, 8'h00,  4'b0000, 4'b0000, 4'b0000);
    add_vec("c1_ack1",   4'b1010, 4'b1010, 4'b0000, D_ALL, 1, 0, 0, 8'h77,  4'b0010, 1, 1, 0, 8'h11,  4'b0010, 4'b0000, 4'b0000);
    add_vec("c1_gap",    4'b1010, 4'b1010, 4'b0000, D_ALL, 0, 0, 0, 8'h77,  4'b0010, 1, 1, 0, 8'h11,  4'b0000, 4'b0000, 4'b0000);
    add_vec("c1_ack2",   4'b1010, 4'b1010, 4'b0000, D_ALL, 1, 0, 0, 8'h78,  4'b0010, 1, 1, 0, 8'h11,  4'b0010, 4'b0000, 4'b0000);
    add_vec("c1_ack3",   4'b1010, 4'b1010, 4'b0000, D_ALL, 1, 0, 0, 8'h79,  4'b0010, 1, 1, 0, 8'h11,  4'b0010, 4'b0000, 4'b0000);
    add_vec("c1_drop",   4'b1000, 4'b1000, 4'b1000, D_ALL, 1, 0, 0, 8'h00,  4'b0010, 0, 0, 0, 8'h11,  4'b0000, 4'b0000, 4'b0000);
    // Response isolation on ctl 3.
    add_vec("c3_err",    4'b1000, 4'b1000, 4'b1000, D_ALL, 0, 1, 0, 8'h00,  4'b1000, 1, 1, 1, 8'h33,  4'b0000, 4'b1000, 4'b0000);
    add_vec("c3_rty",    4'b1000, 4'b1000, 4'b1000, D_ALL, 0, 0, 1, 8'h00,  4'b1000, 1, 1, 1, 8'h33,  4'b0000, 4'b0000, 4'b1000);
    add_vec("c3_ack",    4'b1000, 4'b1000, 4'b1000, D_ALL, 1, 0, 0, 8'hC3,  4'b1000, 1, 1, 1, 8'h33,  4'b1000, 4'b0000, 4'b0000);
    add_vec("c3_nostb",  4'b1000, 4'b0000, 4'b1000, D_ALL, 1, 1, 1, 8'h00,  4'b1000, 1, 0, 1, 8'h33,  4'b1000, 4'b1000, 4'b1000);
    add_vec("c3_drop",   4'b0000, 4'b0000, 4'b0000, D_ALL, 0, 1, 0, 8'h00,  4'b1000, 0, 0, 0, 8'h33,  4'b0000, 4'b0000, 4'b0000);
    add_vec("idle_end",  4'b0000, 4'b0000, 4'b0000, D_ALL, 0, 0, 0, 8'h00,  4'b0000, 0, 0, 0, 8'h00,  4'b0000, 4'b0000, 4'b0000);

    foreach (vecs[i]) begin
      tick();
      ctl_cyc = vecs[i].cyc; ctl_stb = vecs[i].stb; ctl_we = vecs[i].we; ctl_dat = vecs[i].dat;
      dev_ack = vecs[i].ack; dev_err = vecs[i].err; dev_rty = vecs[i].rty; dev_rdat = vecs[i].rdat;
      @(negedge clk);
      check({vecs[i].name, ".gnt"},  32'(gnt),      32'(vecs[i].e_gnt));
      check({vecs[i].name, ".cyc"},  32'(dev_cyc),  32'(vecs[i].e_cyc));
      check({vecs[i].name, ".stb"},  32'(dev_stb),  32'(vecs[i].e_stb));
      check({vecs[i].name, ".we"},   32'(dev_we),   32'(vecs[i].e_we));
      check({vecs[i].name, ".wdat"}, 32'(dev_wdat), 32'(vecs[i].e_dat));
      check({vecs[i].name, ".ack"},  32'(ctl_ack),  32'(vecs[i].e_ack));
      check({vecs[i].name, ".err"},  32'(ctl_err),  32'(vecs[i].e_err));
      check({vecs[i].name, ".rty"},  32'(ctl_rty),  32'(vecs[i].e_rty));
      check({vecs[i].name, ".rdat"}, 32'(ctl_rdat), 32'(vecs[i].rdat));
    end

    // ---- Simultaneous requests: order 0,1,2,3 with no idle gap ----
    tick();
    do_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    dword = D_ALL;
    tick();
    ctl_cyc = 4'b1111; ctl_stb = 4'b1111; ctl_we = 4'b0000; ctl_dat = dword;
    @(negedge clk);
    check("rr_first_idle", 32'(gnt), 32'h0);
    for (int i = 0; i < N; i++) begin
      exp_gnt = exp_q.pop_front();
      tick();
      @(negedge clk);
      check("rr_grant",    32'(gnt),      32'(exp_gnt));
      check("rr_dev_cyc",  32'(dev_cyc),  32'h1);
      check("rr_dev_wdat", 32'(dev_wdat), 32'(dword[i*W +: W]));
      tick();
      ctl_cyc = ctl_cyc & ~exp_gnt;
      ctl_stb = ctl_stb & ~exp_gnt;
      @(negedge clk);
      check("rr_release_held", 32'(gnt),     32'(exp_gnt));
      check("rr_release_cyc",  32'(dev_cyc), 32'h0);
    end
    tick();
    @(negedge clk);
    check("rr_done_idle", 32'(gnt), 32'h0);

    // ---- Reset mid-cycle while ctl 2 awaits ack ----
    tick();
    ctl_cyc = 4'b0100; ctl_stb = 4'b0100; ctl_we = 4'b0000; ctl_dat = D_ALL;
    tick();
    @(negedge clk);
    check("mid_pre_gnt", 32'(gnt),     32'h4);
    check("mid_pre_cyc", 32'(dev_cyc), 32'h1);
    #2;
    rst_n   = 1'b0;
    dev_ack = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(dev_cyc), 32'h0);
    check("mid_rst_stb", 32'(dev_stb), 32'h0);
    check("mid_rst_gnt", 32'(gnt),     32'h0);
    check("mid_rst_ack", 32'(ctl_ack), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    dev_ack = 1'b0;
    ctl_cyc = 4'b0101; ctl_stb = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_gnt",  32'(gnt),      32'h1);
    check("post_rst_wdat", 32'(dev_wdat), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_wb_classic_arbiter
